// File: rtl/re_norm_arbiter_pkg.sv
// Shared widths for the normaliser arbiter slice.
// Result field widths follow from the operand width and requester count.
package re_norm_arbiter_pkg;

    localparam int NUM_REQ    = 4;
    localparam int ID_LENGTH  = $clog2(NUM_REQ);
    localparam int NUM_LENGTH = 32;
    localparam int K_LENGTH   = $clog2(NUM_LENGTH);
    localparam int M1_LENGTH  = 8;

    typedef logic [K_LENGTH-1:0]  k_t;
    typedef logic [M1_LENGTH-1:0] m1_t;

endpackage

// File: rtl/re_lod_norm.sv
// Leading-one detector and fraction extractor.
// Zero input reports k = 0, m1 = 0 and raises zero.
module re_lod_norm
    import re_norm_arbiter_pkg::*;
#(
    parameter int NUM_LENGTH = re_norm_arbiter_pkg::NUM_LENGTH,
    parameter int K_LENGTH   = re_norm_arbiter_pkg::K_LENGTH,
    parameter int M1_LENGTH  = re_norm_arbiter_pkg::M1_LENGTH
) (
    input  logic [NUM_LENGTH-1:0] num,
    output logic [K_LENGTH-1:0]   k,
    output logic [M1_LENGTH-1:0]  m1,
    output logic                  zero
);

    always_comb begin
        k    = '0;
        m1   = '0;
        zero = 1'b1;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < NUM_LENGTH; i++) begin
            if (num[i]) begin
                k    = K_LENGTH'(i);
                zero = 1'b0;
            end
        end
        for (int j = 0; j < M1_LENGTH; j++) begin
            if (int'(k) > j) begin
                m1[M1_LENGTH-1-j] = num[int'(k)-1-j];
            end
        end
    end

endmodule

// File: rtl/re_norm_arbiter.sv
// Round-robin arbiter in front of a shared two-stage normaliser pipeline.
// Stage 1 captures the granted operand; stage 2 holds the tagged result.
module re_norm_arbiter
    import re_norm_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = re_norm_arbiter_pkg::NUM_REQ,
    parameter int ID_LENGTH  = re_norm_arbiter_pkg::ID_LENGTH,
    parameter int NUM_LENGTH = re_norm_arbiter_pkg::NUM_LENGTH,
    parameter int K_LENGTH   = re_norm_arbiter_pkg::K_LENGTH,
    parameter int M1_LENGTH  = re_norm_arbiter_pkg::M1_LENGTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*NUM_LENGTH-1:0] req_num,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_LENGTH-1:0]          out_id,
    output logic [K_LENGTH-1:0]           out_k,
    output logic [M1_LENGTH-1:0]          out_m1,
    output logic                          out_zero,
    output logic                          busy
);

    logic [ID_LENGTH-1:0]  rr_ptr;
    logic [ID_LENGTH-1:0]  idx;
    logic [ID_LENGTH-1:0]  gid;
    logic                  found;
    logic                  s1_en;
    logic                  s2_en;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [ID_LENGTH-1:0]  s1_id;
    logic [NUM_LENGTH-1:0] s1_num;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_LENGTH-1:0] req_arr [NUM_REQ];
    logic [K_LENGTH-1:0]   n_k;
    logic [M1_LENGTH-1:0]  n_m1;
    logic                  n_zero;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_arr[g] = req_num[g*NUM_LENGTH +: NUM_LENGTH];
    end

    assign s2_en = ~s2_valid | out_ready;
    assign s1_en = ~s1_valid | s2_en;

    // Scan from rr_ptr upward; power-of-two NUM_REQ makes the wrap free.
    always_comb begin
        idx   = '0;
        gid   = '0;
        found = 1'b0;
        grant = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = rr_ptr + ID_LENGTH'(o);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = idx;
            end
        end
        if (s1_en && found) begin
            grant[gid] = 1'b1;
        end
    end

    assign req_ready = grant;

    re_lod_norm #(
        .NUM_LENGTH (NUM_LENGTH),
        .K_LENGTH   (K_LENGTH),
        .M1_LENGTH  (M1_LENGTH)
    ) u_norm (
        .num  (s1_num),
        .k    (n_k),
        .m1   (n_m1),
        .zero (n_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_num   <= '0;
            s2_valid <= 1'b0;
            out_id   <= '0;
            out_k    <= '0;
            out_m1   <= '0;
            out_zero <= 1'b0;
        end else begin
            if (|grant) begin
                rr_ptr <= gid + ID_LENGTH'(1);
            end
            if (s1_en) begin
                s1_valid <= |grant;
                s1_id    <= gid;
                s1_num   <= req_arr[gid];
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                out_id   <= s1_id;
                out_k    <= n_k;
                out_m1   <= n_m1;
                out_zero <= n_zero;
            end
        end
    end

    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

endmodule
